wam_mole_gen: RTL and testbench

Mole generator that sits directly upstream of the hit-qualification stage. It produces the `holes` vector, which is the set of holes with a mole currently up, by pseudo-randomly spawning moles and expiring them after a level-dependent lifetime. It retires a mole early when the hit stage reports a hit on it. Expired, unhit moles are reported as per-hole miss pulses to the score logic.

---
 rtl/wam_mole_gen_pkg.sv | 20 ++
 rtl/wam_lfsr16.sv | 23 ++
 rtl/wam_mole_gen.sv | 111 +++++++++++
 tb/tb_wam_mole_gen.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/wam_mole_gen_pkg.sv
// rtl/wam_mole_gen_pkg.sv - shared constants, FSM encoding and LFSR step for the mole generator
package wam_mole_gen_pkg;
   localparam int          WAM_N_HOLES       = 8;
   localparam logic [15:0] WAM_LFSR_TAPS     = 16'hB400;
   localparam logic [15:0] WAM_DEF_SEED      = 16'hACE1;
   localparam int          WAM_DEF_SPAWN_GAP = 6;
   localparam int          WAM_DEF_LIFE      = 12;
   localparam int          WAM_DEF_MAX_UP    = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_SPAWN = 2'd2
   } wam_state_t;

   // Galois right-shift step
   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return (v >> 1) ^ (v[0] ? WAM_LFSR_TAPS : 16'h0000);
   endfunction
endpackage

// File: rtl/wam_lfsr16.sv
// rtl/wam_lfsr16.sv - 16-bit Galois LFSR with enable; exposes its low OUT_W bits
module wam_lfsr16
   import wam_mole_gen_pkg::*;
#(
   parameter logic [15:0] SEED  = WAM_DEF_SEED,
   parameter int          OUT_W = 16
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [OUT_W-1:0] value
);
   logic [15:0] state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= SEED;
      else if (en)
         state <= lfsr_next(state);
   end

   assign value = state[OUT_W-1:0];
endmodule

// File: rtl/wam_mole_gen.sv
// rtl/wam_mole_gen.sv - spawns moles pseudo-randomly, ages them out and reports unhit expiries
module wam_mole_gen
   import wam_mole_gen_pkg::*;
#(
   parameter int          N_HOLES   = WAM_N_HOLES,
   parameter logic [15:0] SEED      = WAM_DEF_SEED,
   parameter int          SPAWN_GAP = WAM_DEF_SPAWN_GAP,
   parameter int          LIFE      = WAM_DEF_LIFE,
   parameter int          MAX_UP    = WAM_DEF_MAX_UP
)(
   input  logic               clk_19,
   input  logic               rst_n,
   input  logic               en,
   input  logic [1:0]         level,
   input  logic [N_HOLES-1:0] hit,
   output logic [N_HOLES-1:0] holes,
   output logic [N_HOLES-1:0] miss,
   output logic [3:0]         up_cnt
);
   localparam logic [3:0] GAP4  = 4'(SPAWN_GAP);
   localparam logic [3:0] LIFE4 = 4'(LIFE);
   localparam logic [3:0] UP4   = 4'(MAX_UP);

   wam_state_t                state;
   logic [3:0]                gap_cnt;
   logic [N_HOLES-1:0][3:0]   life;
   logic [2:0]                start_idx;
   logic [3:0]                life_load;
   logic [3:0]                scan;
   logic                      spawn_ok;

   wam_lfsr16 #(.SEED(SEED), .OUT_W(3)) u_lfsr (
      .clk   (clk_19),
      .rst_n (rst_n),
      .en    (en),
      .value (start_idx)
   );

   // Returns {found, index} of the first free hole at or after s, wrapping.
   function automatic logic [3:0] first_free(input logic [N_HOLES-1:0] occ, input logic [2:0] s);
      logic [2:0] j;
      first_free = 4'b0000;
      for (int k = N_HOLES - 1; k >= 0; k--) begin
         j = s + 3'(k);
         if (!occ[j])
            first_free = {1'b1, j};
      end
   endfunction

   always_comb begin
      up_cnt = 4'd0;
      for (int i = 0; i < N_HOLES; i++)
         up_cnt = up_cnt + {3'b000, holes[i]};
   end

   assign life_load = LIFE4 - {1'b0, level, 1'b0};
   assign scan      = first_free(holes, start_idx);
   assign spawn_ok  = scan[3] && (up_cnt < UP4);

   always_ff @(posedge clk_19 or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         gap_cnt <= 4'd0;
         holes   <= '0;
         miss    <= '0;
         life    <= '0;
      end else if (!en) begin
         state   <= ST_IDLE;
         gap_cnt <= 4'd0;
         holes   <= '0;
         miss    <= '0;
         life    <= '0;
      end else begin
         miss <= '0;
         // A hit on the expiry cycle wins, so no miss is raised for it.
         for (int i = 0; i < N_HOLES; i++) begin
            if (holes[i] && hit[i]) begin
               holes[i] <= 1'b0;
               life[i]  <= 4'd0;
            end else if (holes[i] && life[i] == 4'd1) begin
               holes[i] <= 1'b0;
               life[i]  <= 4'd0;
               miss[i]  <= 1'b1;
            end else if (holes[i]) begin
               life[i]  <= life[i] - 4'd1;
            end
         end
         case (state)
            ST_IDLE: begin
               state   <= ST_WAIT;
               gap_cnt <= GAP4;
            end
            ST_WAIT: begin
               gap_cnt <= gap_cnt - 4'd1;
               if (gap_cnt == 4'd1)
                  state <= ST_SPAWN;
            end
            ST_SPAWN: begin
               state   <= ST_WAIT;
               gap_cnt <= GAP4;
               // The scan sees the pre-edge board, so a hole vacating now is not reused.
               if (spawn_ok) begin
                  holes[scan[2:0]] <= 1'b1;
                  life[scan[2:0]]  <= life_load;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_wam_mole_gen.sv
// tb/tb_wam_mole_gen.sv - event scoreboard bench for wam_mole_gen (default and capped/wrap instances)
module tb_wam_mole_gen;
   typedef struct {
      int         cyc;
      logic [7:0] holes;
      logic [7:0] miss;
      logic [3:0] up;
   } evt_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en_a, en_b;
   logic [1:0] level_a, level_b;
   logic [7:0] hit_a, hit_b;
   logic [7:0] holes_a, miss_a, holes_b, miss_b;
   logic [3:0] up_a, up_b;

   int   cyc    = 0;
   int   errors = 0;
   int   checks = 0;
   evt_t qa[$];
   evt_t qb[$];
   logic [7:0] ph_a = 8'h00, pm_a = 8'h00, ph_b = 8'h00, pm_b = 8'h00;

   wam_mole_gen u_a (
      .clk_19 (clk),
      .rst_n  (rst_n),
      .en     (en_a),
      .level  (level_a),
      .hit    (hit_a),
      .holes  (holes_a),
      .miss   (miss_a),
      .up_cnt (up_a)
   );

   wam_mole_gen #(.SEED(16'h007C), .SPAWN_GAP(1), .LIFE(15), .MAX_UP(3)) u_b (
      .clk_19 (clk),
      .rst_n  (rst_n),
      .en     (en_b),
      .level  (level_b),
      .hit    (hit_b),
      .holes  (holes_b),
      .miss   (miss_b),
      .up_cnt (up_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic cmp(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic push_a(input int c, input logic [7:0] h, input logic [7:0] m, input logic [3:0] u);
      qa.push_back('{c, h, m, u});
   endtask

   task automatic push_b(input int c, input logic [7:0] h, input logic [7:0] m, input logic [3:0] u);
      qb.push_back('{c, h, m, u});
   endtask

   always @(negedge clk) begin
      evt_t e;
      cmp("a_up_popcount", up_a, $countones(holes_a));
      if (holes_a != ph_a || miss_a != pm_a) begin
         if (qa.size() == 0)
            cmp("a_unexpected_event", {holes_a, miss_a}, {ph_a, pm_a});
         else begin
            e = qa.pop_front();
            cmp("a_evt_cycle", cyc, e.cyc);
            cmp("a_holes", holes_a, e.holes);
            cmp("a_miss", miss_a, e.miss);
            cmp("a_up_cnt", up_a, e.up);
         end
         ph_a = holes_a;
         pm_a = miss_a;
      end
   end

   always @(negedge clk) begin
      evt_t e;
      cmp("b_up_popcount", up_b, $countones(holes_b));
      cmp("b_up_cap", int'(up_b > 4'd3), 0);
      if (holes_b != ph_b || miss_b != pm_b) begin
         if (qb.size() == 0)
            cmp("b_unexpected_event", {holes_b, miss_b}, {ph_b, pm_b});
         else begin
            e = qb.pop_front();
            cmp("b_evt_cycle", cyc, e.cyc);
            cmp("b_holes", holes_b, e.holes);
            cmp("b_miss", miss_b, e.miss);
            cmp("b_up_cnt", up_b, e.up);
         end
         ph_b = holes_b;
         pm_b = miss_b;
      end
   end

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Raises en_a, applies up to two one-cycle hit vectors, drops en_a so edge drop_k sees it low.
   task automatic run_main(input logic [1:0] lv, input int drop_k,
                           input int h1_k, input logic [7:0] h1_v,
                           input int h2_k, input logic [7:0] h2_v);
      level_a = lv;
      en_a    = 1'b1;
      for (int k = 1; k <= drop_k; k++) begin
         @(posedge clk);
         @(negedge clk);
         hit_a = (k == h1_k) ? h1_v : (k == h2_k) ? h2_v : 8'h00;
         if (k == drop_k - 1)
            en_a = 1'b0;
      end
      repeat (3) @(negedge clk);
      pulse_reset();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0;
      level_a = 2'd0; level_b = 2'd0; hit_a = 8'h00; hit_b = 8'h00;
      repeat (3) @(negedge clk);
      cmp("rst_holes_a", holes_a, 0);
      cmp("rst_miss_a", miss_a, 0);
      cmp("rst_up_a", up_a, 0);
      cmp("rst_holes_b", holes_b, 0);
      cmp("rst_lfsr_a", u_a.u_lfsr.state, 16'hACE1);
      cmp("rst_lfsr_b", u_b.u_lfsr.state, 16'h007C);
      rst_n = 1'b1;
      repeat (20) begin
         @(negedge clk);
         cmp("idle_lfsr_a", u_a.u_lfsr.state, 16'hACE1);
         cmp("idle_holes_a", holes_a, 0);
      end

      // Level 0, no hits: holes 1 and 3, wrap of 3 onto 4, expiries at 12 cycles
      c0 = cyc;
      push_a(c0 + 8,  8'h02, 8'h00, 4'd1);
      push_a(c0 + 15, 8'h0A, 8'h00, 4'd2);
      push_a(c0 + 20, 8'h08, 8'h02, 4'd1);
      push_a(c0 + 21, 8'h08, 8'h00, 4'd1);
      push_a(c0 + 22, 8'h18, 8'h00, 4'd2);
      push_a(c0 + 27, 8'h10, 8'h08, 4'd1);
      push_a(c0 + 28, 8'h10, 8'h00, 4'd1);
      push_a(c0 + 29, 8'h00, 8'h00, 4'd0);
      run_main(2'd0, 29, 0, 8'h00, 0, 8'h00);

      // Level 3: six-cycle lifetime
      c0 = cyc;
      push_a(c0 + 8,  8'h02, 8'h00, 4'd1);
      push_a(c0 + 14, 8'h00, 8'h02, 4'd0);
      push_a(c0 + 15, 8'h08, 8'h00, 4'd1);
      push_a(c0 + 16, 8'h00, 8'h00, 4'd0);
      run_main(2'd3, 16, 0, 8'h00, 0, 8'h00);

      // Hit on 4th visible cycle; hit on empty hole 5 ignored
      c0 = cyc;
      push_a(c0 + 8,  8'h02, 8'h00, 4'd1);
      push_a(c0 + 12, 8'h00, 8'h00, 4'd0);
      push_a(c0 + 15, 8'h08, 8'h00, 4'd1);
      push_a(c0 + 16, 8'h00, 8'h00, 4'd0);
      run_main(2'd0, 16, 11, 8'h22, 0, 8'h00);

      // Hit on expiry cycle wins; hit one cycle after expiry is ignored
      c0 = cyc;
      push_a(c0 + 8,  8'h02, 8'h00, 4'd1);
      push_a(c0 + 15, 8'h0A, 8'h00, 4'd2);
      push_a(c0 + 20, 8'h08, 8'h00, 4'd1);
      push_a(c0 + 22, 8'h18, 8'h00, 4'd2);
      push_a(c0 + 27, 8'h10, 8'h08, 4'd1);
      push_a(c0 + 28, 8'h10, 8'h00, 4'd1);
      push_a(c0 + 29, 8'h00, 8'h00, 4'd0);
      run_main(2'd0, 29, 19, 8'h02, 27, 8'h08);

      // Capped instance: hole 7, wrap to 0, hole 1, then skipped slots; en drop clears silently
      c0 = cyc;
      push_b(c0 + 3,  8'h80, 8'h00, 4'd1);
      push_b(c0 + 5,  8'h81, 8'h00, 4'd2);
      push_b(c0 + 7,  8'h83, 8'h00, 4'd3);
      push_b(c0 + 12, 8'h00, 8'h00, 4'd0);
      en_b = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 11)
            en_b = 1'b0;
      end
      c0 = cyc;
      push_b(c0 + 3, 8'h08, 8'h00, 4'd1);
      push_b(c0 + 4, 8'h00, 8'h00, 4'd0);
      en_b = 1'b1;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      en_b  = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) begin
         @(negedge clk);
         cmp("post_rst_lfsr_b", u_b.u_lfsr.state, 16'h007C);
         cmp("post_rst_holes_b", holes_b, 0);
         cmp("post_rst_miss_b", miss_b, 0);
      end

      cmp("a_queue_drained", qa.size(), 0);
      cmp("b_queue_drained", qb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
